// File: rtl/rocketcpu_pkg.sv
// Shared definitions for the word-copy DMA: register map, CTRL bits, FSM encoding.
// No logic; constants and types only.
// Initiator request bundle is kept as one packed struct so it registers as a unit.
package rocketcpu_pkg;

  // Slave register offsets, decoded from adr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_ABORT    = 3;

  // CTRL read (status) bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

  // Registered initiator request
  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } m_req_t;

endpackage

// File: rtl/rocketcpu_dma_regs.sv
// Wishbone slave register file for the DMA: SRC/DST/LEN/CTRL plus done/irq_en state.
// Latency: ack and read data registered, one cycle after cyc rises; single ack per cyc.
// Backpressure: none; every access is acked once, writes to busy-locked registers are dropped.
module rocketcpu_dma_regs
  import rocketcpu_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             wb_clk,
  input  logic             reset,
  input  logic [31:0]      i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic             busy,
  input  logic             done_set,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             irq_en,
  output logic             done,
  output logic             start,
  output logic             abort
);

  logic        cyc_q;
  logic        wb_hit;
  logic        wr_en;
  logic        ctrl_wr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_mux;

  // Address bits outside [3:2] and byte selects carry no meaning here
  wire unused_ok = &{1'b0, i_wb_sel, i_wb_adr[31:4], i_wb_adr[1:0]};

  // An access is served only on the rising edge of cyc, so a held cyc cannot double-ack
  assign wb_hit  = i_wb_cyc & ~cyc_q;
  assign wr_en   = wb_hit & i_wb_we;
  assign reg_sel = i_wb_adr[3:2];
  assign ctrl_wr = wr_en & (reg_sel == REG_CTRL);
  assign start   = ctrl_wr & i_wb_dat[CTRL_START] & ~busy;
  assign abort   = ctrl_wr & i_wb_dat[CTRL_ABORT] & busy;

  // Read mux; LEN is zero-extended
  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      REG_SRC:  rd_mux = src;
      REG_DST:  rd_mux = dst;
      REG_LEN:  rd_mux = {{(32 - LEN_W){1'b0}}, len};
      default: begin
        rd_mux[STAT_BUSY]   = busy;
        rd_mux[STAT_DONE]   = done;
        rd_mux[STAT_IRQ_EN] = irq_en;
      end
    endcase
  end

  // Slave handshake: one-cycle ack, read data only while ack is high
  always_ff @(posedge wb_clk) begin
    if (reset) begin
      cyc_q    <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
    end else begin
      cyc_q    <= i_wb_cyc;
      o_wb_ack <= wb_hit;
      o_wb_rdt <= (wb_hit & ~i_wb_we) ? rd_mux : 32'd0;
    end
  end

  // Register file; address registers are locked while a transfer runs
  always_ff @(posedge wb_clk) begin
    if (reset) begin
      src    <= 32'd0;
      dst    <= 32'd0;
      len    <= '0;
      irq_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (wr_en && !busy) begin
        case (reg_sel)
          REG_SRC: src <= {i_wb_dat[31:2], 2'b00};
          REG_DST: dst <= {i_wb_dat[31:2], 2'b00};
          REG_LEN: len <= i_wb_dat[LEN_W-1:0];
          default: ;
        endcase
      end
      if (ctrl_wr) irq_en <= i_wb_dat[CTRL_IRQ_EN];
      // Completion beats start (zero-length start completes at once); start beats clear
      if (done_set)                            done <= 1'b1;
      else if (start)                          done <= 1'b0;
      else if (ctrl_wr && i_wb_dat[CTRL_CLR_DONE]) done <= 1'b0;
    end
  end

endmodule

// File: rtl/rocketcpu_dma.sv
// Single-channel word-copy DMA: reads SRC, writes DST, LEN words, irq on completion.
// Latency: 2 bus transactions per word, each followed by a one-cycle cyc gap (4 cycles/word at zero wait).
// Backpressure: holds cyc/adr/we/dat stable until i_m_ack; abort waits for the in-flight ack.
module rocketcpu_dma
  import rocketcpu_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_m_adr,
  output logic [31:0] o_m_dat,
  output logic [3:0]  o_m_sel,
  output logic        o_m_we,
  output logic        o_m_cyc,
  input  logic [31:0] i_m_rdt,
  input  logic        i_m_ack,
  output logic        o_irq
);

  dma_state_t       state;
  m_req_t           req;
  logic [31:0]      src, dst, addr_src, addr_dst, rbuf;
  logic [LEN_W-1:0] len, count;
  logic             irq_en, done, start, abort, busy, done_set;
  logic             abort_pend, abort_any, m_done, gap_abort, last_xfer;

  rocketcpu_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .wb_clk   (i_wb_clk),
    .reset    (reset),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .busy     (busy),
    .done_set (done_set),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .irq_en   (irq_en),
    .done     (done),
    .start    (start),
    .abort    (abort)
  );

  assign busy      = (state != IDLE);
  assign abort_any = abort_pend | abort;
  assign m_done    = req.cyc & i_m_ack;
  // An abort seen during the inter-transaction gap stops before issuing anything new
  assign gap_abort = busy & ~req.cyc & abort_any;
  assign last_xfer = m_done & (((state == RD) & abort_any) |
                               ((state == WR) & ((count == LEN_W'(1)) | abort_any)));
  assign done_set  = ((state == IDLE) & start & (len == '0)) | last_xfer | gap_abort;

  assign o_m_cyc = req.cyc;
  assign o_m_we  = req.we;
  assign o_m_adr = req.adr;
  assign o_m_dat = req.dat;
  assign o_m_sel = 4'hF;
  assign o_irq   = done & irq_en;

  // Copy FSM: IDLE -> RD -> gap -> WR -> gap -> RD ... with registered initiator request
  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      state      <= IDLE;
      req        <= '0;
      addr_src   <= 32'd0;
      addr_dst   <= 32'd0;
      count      <= '0;
      rbuf       <= 32'd0;
      abort_pend <= 1'b0;
    end else begin
      if (abort) abort_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            addr_src   <= src;
            addr_dst   <= dst;
            count      <= len;
            abort_pend <= 1'b0;
            if (len != '0) begin
              state   <= RD;
              req.cyc <= 1'b1;
              req.we  <= 1'b0;
              req.adr <= src;
            end
          end
        end
        RD: begin
          if (!req.cyc) begin
            if (abort_any) begin
              state <= IDLE;
            end else begin
              req.cyc <= 1'b1;
              req.we  <= 1'b0;
              req.adr <= addr_src;
            end
          end else if (i_m_ack) begin
            rbuf    <= i_m_rdt;
            req.cyc <= 1'b0;
            state   <= abort_any ? IDLE : WR;
          end
        end
        WR: begin
          if (!req.cyc) begin
            if (abort_any) begin
              state <= IDLE;
            end else begin
              req.cyc <= 1'b1;
              req.we  <= 1'b1;
              req.adr <= addr_dst;
              req.dat <= rbuf;
            end
          end else if (i_m_ack) begin
            req.cyc  <= 1'b0;
            req.we   <= 1'b0;
            addr_src <= addr_src + 32'd4;
            addr_dst <= addr_dst + 32'd4;
            count    <= count - LEN_W'(1);
            state    <= ((count == LEN_W'(1)) || abort_any) ? IDLE : RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rocketcpu_dma.sv
// Directed self-checking bench for rocketcpu_dma with a wait-state initiator memory model.
// Memory returns adr + 0x1111_0000 for every read; writes are logged for checking.
// CPU-side accesses are single Wishbone cycles driven at the falling edge.
module tb_rocketcpu_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_wb_adr = 32'd0;
  logic [31:0] i_wb_dat = 32'd0;
  logic [3:0]  i_wb_sel = 4'hF;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [31:0] o_m_adr, o_m_dat;
  logic [3:0]  o_m_sel;
  logic        o_m_we, o_m_cyc;
  logic [31:0] i_m_rdt;
  logic        i_m_ack;
  logic        o_irq;

  int checks = 0;
  int failures = 0;

  // Memory model state
  int          waits = 0;
  int          wcnt = 0;
  logic        clr_log = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, cyc_seen = 0;
  logic        unstable = 1'b0, hold_vld = 1'b0;
  logic [64:0] held = '0;
  logic [31:0] rd_adr [0:15];
  logic [31:0] wr_adr [0:15];
  logic [31:0] wr_dat [0:15];

  rocketcpu_dma #(.LEN_W(16)) dut (
    .i_wb_clk (clk),
    .reset    (reset),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_sel (i_wb_sel),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_m_adr  (o_m_adr),
    .o_m_dat  (o_m_dat),
    .o_m_sel  (o_m_sel),
    .o_m_we   (o_m_we),
    .o_m_cyc  (o_m_cyc),
    .i_m_rdt  (i_m_rdt),
    .i_m_ack  (i_m_ack),
    .o_irq    (o_irq)
  );

  always #5 clk = ~clk;

  assign i_m_ack = o_m_cyc && (wcnt == waits);
  assign i_m_rdt = o_m_adr + 32'h1111_0000;

  always @(posedge clk) begin
    if (o_m_cyc && !i_m_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  always @(posedge clk) begin
    if (clr_log) begin
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      cyc_seen <= 0;
      unstable <= 1'b0;
      hold_vld <= 1'b0;
    end else begin
      if (o_m_cyc) cyc_seen <= cyc_seen + 1;
      if (o_m_cyc && i_m_ack) begin
        if (o_m_we) begin
          if (wr_cnt < 16) begin
            wr_adr[wr_cnt] <= o_m_adr;
            wr_dat[wr_cnt] <= o_m_dat;
          end
          wr_cnt <= wr_cnt + 1;
        end else begin
          if (rd_cnt < 16) rd_adr[rd_cnt] <= o_m_adr;
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (o_m_cyc && hold_vld && ({o_m_adr, o_m_we, o_m_dat} != held)) unstable <= 1'b1;
      hold_vld <= o_m_cyc && !i_m_ack;
      held     <= {o_m_adr, o_m_we, o_m_dat};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_clr_log();
    @(negedge clk);
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] reg_idx, input logic [31:0] dat);
    bit got;
    got = 1'b0;
    @(negedge clk);
    i_wb_adr = {28'h0300_000, reg_idx, 2'b00};
    i_wb_dat = dat;
    i_wb_we  = 1'b1;
    i_wb_cyc = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) got = 1'b1;
    end
    @(negedge clk);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    check("wb_write_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_read(input logic [1:0] reg_idx, output logic [31:0] dat);
    bit got;
    got = 1'b0;
    dat = 32'hxxxx_xxxx;
    @(negedge clk);
    i_wb_adr = {28'h0300_000, reg_idx, 2'b00};
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) begin
        got = 1'b1;
        dat = o_wb_rdt;
      end
    end
    @(negedge clk);
    i_wb_cyc = 1'b0;
    check("wb_read_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 100 && !idle; n++) begin
      wb_read(2'd3, st);
      if (st[0] == 1'b0) idle = 1'b1;
    end
    check(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    int acks;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_cyc", {31'd0, o_m_cyc}, 32'd0);
    check("rst_wb_ack", {31'd0, o_wb_ack}, 32'd0);
    check("rst_irq", {31'd0, o_irq}, 32'd0);
    check("rst_m_adr", o_m_adr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wb_read(2'd3, rd);
    check("rst_ctrl", rd, 32'd0);

    // 3-word copy, zero wait states, irq enabled
    waits = 0;
    do_clr_log();
    wb_write(2'd0, 32'h0010_0003);     // low bits must be dropped
    wb_write(2'd1, 32'h0000_0100);
    wb_write(2'd2, 32'd3);
    wb_write(2'd3, 32'h3);
    n = 0;
    while (!o_irq && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_irq_latency", n, 32'd11);
    check("t1_rd_cnt", rd_cnt, 32'd3);
    check("t1_wr_cnt", wr_cnt, 32'd3);
    check("t1_rd0", rd_adr[0], 32'h0010_0000);
    check("t1_rd1", rd_adr[1], 32'h0010_0004);
    check("t1_rd2", rd_adr[2], 32'h0010_0008);
    check("t1_wr0_adr", wr_adr[0], 32'h0000_0100);
    check("t1_wr1_adr", wr_adr[1], 32'h0000_0104);
    check("t1_wr2_adr", wr_adr[2], 32'h0000_0108);
    check("t1_wr0_dat", wr_dat[0], 32'h1121_0000);
    check("t1_wr1_dat", wr_dat[1], 32'h1121_0004);
    check("t1_wr2_dat", wr_dat[2], 32'h1121_0008);
    wb_read(2'd3, rd);
    check("t1_ctrl", rd, 32'h6);
    wb_read(2'd0, rd);
    check("t1_src_kept", rd, 32'h0010_0000);
    wb_read(2'd2, rd);
    check("t1_len_kept", rd, 32'd3);

    // Zero-length start: no bus activity, done immediately
    wb_write(2'd3, 32'h4);
    check("t2_irq_cleared", {31'd0, o_irq}, 32'd0);
    wb_read(2'd3, rd);
    check("t2_ctrl_cleared", rd, 32'd0);
    do_clr_log();
    wb_write(2'd2, 32'd0);
    wb_write(2'd3, 32'h3);
    check("t2_irq_next_cycle", {31'd0, o_irq}, 32'd1);
    wb_read(2'd3, rd);
    check("t2_ctrl", rd, 32'h6);
    check("t2_no_cyc", cyc_seen, 32'd0);

    // 5 wait states per access, busy visible, request stable
    waits = 5;
    wb_write(2'd0, 32'h0000_2000);
    wb_write(2'd1, 32'h0000_3000);
    wb_write(2'd2, 32'd2);
    do_clr_log();
    wb_write(2'd3, 32'h1);
    wb_read(2'd3, rd);
    check("t3_busy_a", rd, 32'h1);
    wb_read(2'd3, rd);
    check("t3_busy_b", rd, 32'h1);
    wb_read(2'd3, rd);
    check("t3_busy_c", rd, 32'h1);
    wait_idle("t3_idle_timeout");
    check("t3_stable", {31'd0, unstable}, 32'd0);
    check("t3_rd_cnt", rd_cnt, 32'd2);
    check("t3_wr_cnt", wr_cnt, 32'd2);
    check("t3_wr0_adr", wr_adr[0], 32'h0000_3000);
    check("t3_wr1_adr", wr_adr[1], 32'h0000_3004);
    check("t3_wr0_dat", wr_dat[0], 32'h1111_2000);
    check("t3_wr1_dat", wr_dat[1], 32'h1111_2004);
    wb_read(2'd3, rd);
    check("t3_ctrl_done", rd, 32'h2);

    // Abort during the write of the third word of eight
    waits = 3;
    wb_write(2'd0, 32'h0000_4000);
    wb_write(2'd1, 32'h0000_5000);
    wb_write(2'd2, 32'd8);
    do_clr_log();
    wb_write(2'd3, 32'h1);
    n = 0;
    while (!(o_m_cyc && o_m_we && wr_cnt == 2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_reach_wr3", {31'd0, (n < 300)}, 32'd1);
    wb_write(2'd3, 32'h8);
    wait_idle("t4_idle_timeout");
    check("t4_wr_cnt", wr_cnt, 32'd3);
    check("t4_rd_cnt", rd_cnt, 32'd3);
    check("t4_last_adr", wr_adr[2], 32'h0000_5008);
    check("t4_last_dat", wr_dat[2], 32'h1111_4008);
    wb_read(2'd3, rd);
    check("t4_ctrl_done", rd, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_more_wr", wr_cnt, 32'd3);
    check("t4_no_more_rd", rd_cnt, 32'd3);

    // cyc held for 4 cycles on one read: single ack
    acks = 0;
    rd = 32'd0;
    @(negedge clk);
    i_wb_adr = 32'h0300_0000;
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) begin
        acks++;
        rd = o_wb_rdt;
      end
    end
    @(negedge clk);
    i_wb_cyc = 1'b0;
    check("t5_single_ack", acks, 32'd1);
    check("t5_src_read", rd, 32'h0000_4000);

    // Write to SRC while busy is dropped
    wb_write(2'd0, 32'h0000_6000);
    wb_write(2'd1, 32'h0000_7000);
    wb_write(2'd2, 32'd4);
    wb_write(2'd3, 32'h3);
    wb_write(2'd0, 32'hDEAD_0000);
    wb_read(2'd0, rd);
    check("t5_src_locked", rd, 32'h0000_6000);

    // Reset while a read is in flight
    n = 0;
    while (!(o_m_cyc && !o_m_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_rd", {31'd0, (n < 100)}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_cyc_drop", {31'd0, o_m_cyc}, 32'd0);
    check("t6_irq", {31'd0, o_irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wb_read(2'd0, rd);
    check("t6_src", rd, 32'd0);
    wb_read(2'd1, rd);
    check("t6_dst", rd, 32'd0);
    wb_read(2'd2, rd);
    check("t6_len", rd, 32'd0);
    wb_read(2'd3, rd);
    check("t6_ctrl", rd, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_idle_bus", {31'd0, o_m_cyc}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
